// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle a - b - bin with the borrow rippled DIGIT bits per clock; valid/ready on both sides.
// Optional macro SUB_SATURATE_EN clamps diff to the signed range when ovf is set.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept_c;
  logic             last_c;
  logic [DIGIT:0]   dsub_c;
  logic [WIDTH-1:0] raw_c;
  logic [WIDTH-1:0] final_c;
  logic             ovf_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (last_c)   state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready is gated by rst_n so it drops while reset is held
  always_comb begin
    in_ready  = (state_q == IDLE) & rst_n;
    out_valid = (state_q == DONE);
  end

  assign accept_c = (state_q == IDLE) & in_valid;
  assign last_c   = (cnt_q == CW'(NDIG - 1));

  // One digit of the borrow chain; operands are shifted down so the live digit is always at bit 0
  assign dsub_c = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT + 1)'(brw_q);

  // Result digits enter at the top and settle into place after NDIG shifts
  assign raw_c = (diff_q >> DIGIT) | (WIDTH'(dsub_c[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign ovf_c = (a_msb_q ^ b_msb_q) & (raw_c[WIDTH-1] ^ a_msb_q);

`ifdef SUB_SATURATE_EN
  logic [WIDTH-1:0] sat_c;
  assign sat_c   = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_c = ovf_c ? sat_c : raw_c;
`else
  assign final_c = raw_c;
`endif

  // Datapath next-state: latch on accept, step one digit per CALC cycle, flags on the last digit
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept_c) begin
      a_d     = a;
      b_d     = b;
      brw_d   = bin;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == CALC) begin
      a_d    = a_q >> DIGIT;
      b_d    = b_q >> DIGIT;
      brw_d  = dsub_c[DIGIT];
      cnt_d  = cnt_q + CW'(1);
      diff_d = raw_c;
      if (last_c) begin
        diff_d = final_c;
        bout_d = dsub_c[DIGIT];
        ovf_d  = ovf_c;
        zero_d = (raw_c == '0);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
